// File: rtl/mealy_seq_detector_param.sv
// -----------------------------------------------------------------------------
// mealy_seq_detector_param
//
// Parametrised Mealy serial pattern detector. It watches a 1-bit qualified
// stream and flags the cycle on which the last bit of PATTERN arrives. The
// pattern is received MSB first. Detection can overlap or not, selected at
// runtime, and a synchronous clear empties the history.
//
// Parameters
//   PAT_LEN  pattern length in bits (1..16)
//   PATTERN  pattern to detect, PAT_LEN bits, MSB received first
//   CNT_W    width of the match counter
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   clr           synchronous clear of history, fill and counter, active high
//   in_valid      in_seq carries a stream bit this cycle
//   in_seq        serial data bit
//   overlap       1 = overlapping detection, 0 = non-overlapping
//   seq_detected  match flag, combinational from the current input bit
//   match_cnt     saturating count of matches
//
// Build option
//   MATCH_CNT_EN  when defined, match_cnt counts matches and saturates at
//                 2**CNT_W-1. When undefined, match_cnt is tied to zero.
// -----------------------------------------------------------------------------
module mealy_seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_seq,
    input  logic             overlap,
    output logic             seq_detected,
    output logic [CNT_W-1:0] match_cnt
);

    // History width. A single-bit pattern needs no history, but a one-bit
    // dummy register keeps the declarations legal.
    localparam int         HW       = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
    localparam logic [4:0] FILL_MAX = 5'(PAT_LEN - 1);

    localparam logic FILLING = 1'b0;
    localparam logic ARMED   = 1'b1;

    logic [HW-1:0] hist;
    logic [4:0]    fill;
    logic          state;
    logic [HW:0]   window;
    logic          win_match;

    // The state follows directly from the fill level. Storing it separately
    // would only add a second copy of the same information that could disagree.
    assign state  = (fill == FILL_MAX) ? ARMED : FILLING;
    assign window = {hist, in_seq};

    generate
        if (PAT_LEN == 1) begin : g_single
            assign win_match = (in_seq == PATTERN[0]);
        end else begin : g_multi
            assign win_match = (window == PATTERN);
        end
    endgenerate

    // rst is part of the product so the flag drops as soon as reset asserts.
    // It does not wait for the registers to clear.
    assign seq_detected = rst & ~clr & in_valid & (state == ARMED) & win_match;

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge and the order of the statements
    // does not matter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= window[HW-1:0];
            if (seq_detected && !overlap) begin
                // Non-overlapping mode: the next match needs PAT_LEN fresh bits.
                // The contents of hist do not matter once fill is zero.
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + 5'd1;
            end
        end
    end

`ifdef MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (clr) begin
            match_cnt <= '0;
        end else if (seq_detected && (match_cnt != CNT_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
        end
    end
`else
    assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_mealy_seq_detector_param
//
// Bench for mealy_seq_detector_param with PAT_LEN=4, PATTERN=1101, CNT_W=8.
// Each stimulus step pushes its expected flag, and the counter value expected
// before that edge, into a queue. A monitor pops each entry mid-cycle and
// compares it with the DUT outputs. The scenario tasks add their own inline
// comparisons for reset and counter end values.
// -----------------------------------------------------------------------------
module tb_mealy_seq_detector_param;

`ifdef MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_seq = 1'b0;
    logic       overlap = 1'b1;
    logic       seq_detected;
    logic [7:0] match_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       flag;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] exp_cnt = 8'd0;

    mealy_seq_detector_param #(
        .PAT_LEN (4),
        .PATTERN (4'b1101),
        .CNT_W   (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_seq       (in_seq),
        .overlap      (overlap),
        .seq_detected (seq_detected),
        .match_cnt    (match_cnt)
    );

    always #10 clk = ~clk;

    // Scoreboard monitor. It samples 2 time units after the falling edge,
    // well away from the rising edge.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (seq_detected !== e.flag) begin
                failures++;
                $display("FAIL flag @%0t: got %b expected %b", $time, seq_detected, e.flag);
            end
            checks++;
            if (match_cnt !== e.cnt) begin
                failures++;
                $display("FAIL match_cnt @%0t: got %0d expected %0d", $time, match_cnt, e.cnt);
            end
        end
    end

    // Drive one cycle of stimulus and queue its expectation. Then advance the
    // counter model to the value expected after the coming rising edge.
    task automatic drive(input logic v, input logic s, input logic ovl,
                         input logic c, input logic e);
        exp_t x;
        @(negedge clk);
        in_valid = v;
        in_seq   = s;
        overlap  = ovl;
        clr      = c;
        x.flag   = e;
        x.cnt    = exp_cnt;
        exp_q.push_back(x);
        if (!rst || c)
            exp_cnt = 8'd0;
        else if (e && CNT_ON && exp_cnt != 8'hFF)
            exp_cnt = exp_cnt + 8'd1;
    endtask

    // Send n valid bits. bits[n-1] goes first, and flags holds the expected
    // detector output for each bit.
    task automatic send(input int n, input logic [15:0] bits,
                        input logic [15:0] flags, input logic ovl);
        for (int i = n - 1; i >= 0; i--)
            drive(1'b1, bits[i], ovl, 1'b0, flags[i]);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, overlap, 1'b0, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b1, 1'b1, overlap, 1'b1, 1'b0);
    endtask

    task automatic expect_cnt(input string name, input logic [7:0] want);
        #3;
        checks++;
        if (match_cnt !== want) begin
            failures++;
            $display("FAIL %s: match_cnt got %0d expected %0d", name, match_cnt, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (seq_detected !== 1'b0 || match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_hold: got flag=%b cnt=%0d expected 0/0", seq_detected, match_cnt);
        end
        @(negedge clk);
        #5;
        in_valid = 1'b0;
        rst = 1'b1;
        idle();
        expect_cnt("reset_release", 8'd0);
    endtask

    task automatic test_overlap();
        send(7, 16'b1101101, 16'b0001001, 1'b1);
        idle();
        expect_cnt("overlap_cnt", CNT_ON ? 8'd2 : 8'd0);
    endtask

    task automatic test_non_overlap();
        overlap = 1'b0;
        do_clr();
        send(7, 16'b1101101, 16'b0001000, 1'b0);
        idle();
        expect_cnt("nonoverlap_cnt_a", CNT_ON ? 8'd1 : 8'd0);
        do_clr();
        send(8, 16'b11011101, 16'b00010001, 1'b0);
        idle();
        expect_cnt("nonoverlap_cnt_b", CNT_ON ? 8'd2 : 8'd0);
    endtask

    task automatic test_gaps();
        overlap = 1'b1;
        do_clr();
        send(3, 16'b110, 16'b000, 1'b1);
        // The gap bits carry a 1 that would complete the pattern if it were accepted.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idle();
        expect_cnt("gap_cnt", CNT_ON ? 8'd1 : 8'd0);
    endtask

    task automatic test_rst_mid();
        // Continue from the previous history, which holds a nonzero count.
        send(3, 16'b110, 16'b000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_seq   = 1'b1;
        #2;
        checks++;
        if (seq_detected !== 1'b0 || match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL rst_pulse: got flag=%b cnt=%0d expected 0/0", seq_detected, match_cnt);
        end
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_cnt  = 8'd0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(4, 16'b1101, 16'b0001, 1'b1);
        idle();
        expect_cnt("rst_mid_cnt", CNT_ON ? 8'd1 : 8'd0);
    endtask

    task automatic test_clr_mid();
        send(3, 16'b110, 16'b000, 1'b1);
        do_clr();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(4, 16'b1101, 16'b0001, 1'b1);
        idle();
        expect_cnt("clr_mid_cnt", CNT_ON ? 8'd1 : 8'd0);
    endtask

    task automatic test_saturation();
        do_clr();
        for (int r = 0; r < 300; r++)
            send(4, 16'b1101, 16'b0001, 1'b1);
        idle();
        expect_cnt("saturation_cnt", CNT_ON ? 8'd255 : 8'd0);
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_gaps();
        test_rst_mid();
        test_clr_mid();
        test_saturation();
        @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
